fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Multicycle instruction-fetch controller for the MIPS processor.
- Owns the PC register and drives an instruction-memory request/acknowledge handshake.
- Presents each fetched instruction to decode with a valid/stall handshake.
- Sequences next-PC selection: sequential (PC+4), J-type jump (26-bit target shifted left 2, upper 4 bits from PC+4), or branch (sign-extended 16-bit offset shifted left 2, added to PC+4).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- WAIT_LIMIT, 15, maximum extra REQ cycles tolerated without imem_ack before fault (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  permits new fetches to start.
- imem_req  out  1  instruction-memory request, held until ack.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory acknowledge; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  registered instruction to decode.
- instr_pc  out  32  address of instr.
- instr_valid  out  1  instr/instr_pc valid.
- stall  in  1  decode not ready; instruction is accepted when instr_valid=1 and stall=0.
- jump  in  1  redirect via jump target, sampled on accept.
- jump_target  in  26  J-type target field.
- branch  in  1  taken-branch redirect, sampled on accept.
- branch_offset  in  16  branch immediate.
- fetch_fault  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (rst_n=0, asynchronous and immediate, also mid-transaction):
  - state=IDLE, pc=RESET_PC, wait_cnt=0.
  - imem_req=0, imem_addr=0, instr=0, instr_pc=0, instr_valid=0, fetch_fault=0.
- States: IDLE, REQ, VALID, FAULT (registered, encoded internally).
- IDLE:
  - Outputs imem_req=0, instr_valid=0.
  - enable=1 -> REQ next cycle with wait_cnt cleared.
- REQ:
  - imem_req=1, imem_addr=pc.
  - imem_ack=1 -> latch instr=imem_rdata and instr_pc=pc; go to VALID. instr_valid rises the next cycle (1-cycle latency from ack).
  - No ack -> wait_cnt++.
  - No ack in the cycle where wait_cnt==WAIT_LIMIT -> FAULT.
  - Dropping enable in REQ does not abort; the transaction completes normally.
- VALID:
  - instr_valid=1; instr/instr_pc stable.
  - stall=1: hold everything; jump/branch ignored.
  - stall=0 (accept): compute p4 = instr_pc + 4, modulo 2^32, then
    - jump=1: pc <= {p4[31:28], jump_target, 2'b00}.
    - else branch=1: pc <= p4 + {{14{branch_offset[15]}}, branch_offset, 2'b00}, modulo 2^32.
    - else: pc <= p4.
  - jump and branch both high: jump wins.
  - After accept: instr_valid drops next cycle; next state is REQ if enable=1, else IDLE.
- FAULT:
  - fetch_fault=1, imem_req=0, instr_valid=0.
  - Terminal until reset; all inputs ignored.
- imem_ack outside REQ is ignored; imem_rdata is sampled only on ack in REQ.
- Throughput: zero-wait memory gives one instruction per 2 cycles (REQ, VALID).
- pc wrap: 32'hFFFF_FFFC + 4 -> 32'h0000_0000; no flag raised.
- imem_addr holds its last value when imem_req=0.

Test Plan:
- Reset/sequential: RESET_PC=0; enable=1; ack in the first REQ cycle every time; stall=0 -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid alternates 1/0; instr equals the supplied words.
- Jump: instr_pc=0x4000_0010; accept with jump=1, jump_target=26'h0000100 -> next imem_addr=0x4000_0400. Repeat with branch=1 also high -> jump still wins.
- Branch negative/wrap:
  - instr_pc=0x0000_0020, branch_offset=16'hFFFE -> next imem_addr=0x0000_001C.
  - instr_pc=0xFFFF_FFFC, no redirect -> next imem_addr=0x0000_0000.
- Stall: hold stall=1 for 5 cycles in VALID while toggling jump -> instr_valid and instr stay constant and no imem_req is issued. Release stall with jump=0 -> next imem_addr = instr_pc+4.
- Timeout: WAIT_LIMIT=3, never ack -> imem_req high for exactly 4 cycles; fetch_fault=1 from the next cycle and stays sticky. Ack on the 4th cycle instead -> no fault, normal VALID.
- Async reset mid-REQ: assert rst_n=0 between clock edges while imem_req=1 -> imem_req, instr_valid and fetch_fault go to 0 immediately. After release, first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Multicycle instruction-fetch controller. It owns the PC, issues one
// instruction-memory request at a time, and hands each fetched word to decode
// through a valid/stall handshake. On every accepted instruction it selects
// the next PC: sequential (PC+4), J-type jump, or taken branch.
//
// Ports:
//   clk_i, rst_ni         clock (rising edge), asynchronous active-low reset
//   enable_i              allows a new fetch to start from IDLE or after accept
//   imem_req_o            memory request, held until imem_ack_i
//   imem_addr_o           fetch address (pc while requesting, else last value)
//   imem_ack_i            memory acknowledge, imem_rdata_i valid same cycle
//   imem_rdata_i          fetched instruction word
//   instr_o, instr_pc_o   registered instruction and its address
//   instr_valid_o         instr_o/instr_pc_o valid for decode
//   stall_i               decode not ready; accept = instr_valid_o & ~stall_i
//   jump_i, jump_target_i J-type redirect, sampled on accept
//   branch_i, branch_offset_i  taken-branch redirect, sampled on accept
//   fetch_fault_o         sticky memory-timeout flag
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [25:0] jump_target_i,
    input  logic        branch_i,
    input  logic [15:0] branch_offset_i,
    output logic        fetch_fault_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_VALID,
        S_FAULT
    } state_e;

    localparam logic [7:0] WAIT_LIMIT_C = 8'(WAIT_LIMIT);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    // Last address presented while requesting; keeps imem_addr_o steady
    // when no request is active.
    logic [31:0] addr_hold_q, addr_hold_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_disp;
    logic [31:0] jump_pc;
    logic [31:0] branch_pc;

    // Redirects are relative to the instruction being accepted, not to pc_q.
    assign pc_plus4    = instr_pc_q + 32'd4;
    assign branch_disp = {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};
    assign jump_pc     = {pc_plus4[31:28], jump_target_i, 2'b00};
    assign branch_pc   = pc_plus4 + branch_disp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            wait_cnt_q  <= 8'd0;
            instr_q     <= 32'd0;
            instr_pc_q  <= 32'd0;
            addr_hold_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wait_cnt_q  <= wait_cnt_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            addr_hold_q <= addr_hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wait_cnt_d  = wait_cnt_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        addr_hold_d = addr_hold_q;

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d    = S_REQ;
                    wait_cnt_d = 8'd0;
                end
            end
            S_REQ: begin
                addr_hold_d = pc_q;
                if (imem_ack_i) begin
                    instr_d    = imem_rdata_i;
                    instr_pc_d = pc_q;
                    state_d    = S_VALID;
                end else if (wait_cnt_q == WAIT_LIMIT_C) begin
                    state_d = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_VALID: begin
                if (!stall_i) begin
                    // Jump has priority over branch when both are raised.
                    if (jump_i) begin
                        pc_d = jump_pc;
                    end else if (branch_i) begin
                        pc_d = branch_pc;
                    end else begin
                        pc_d = pc_plus4;
                    end
                    wait_cnt_d = 8'd0;
                    state_d    = enable_i ? S_REQ : S_IDLE;
                end
            end
            S_FAULT: begin
                // Terminal until reset.
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs decode directly from the state register so an
    // asynchronous reset clears them without waiting for a clock edge.
    assign imem_req_o    = (state_q == S_REQ);
    assign imem_addr_o   = imem_req_o ? pc_q : addr_hold_q;
    assign instr_valid_o = (state_q == S_VALID);
    assign fetch_fault_o = (state_q == S_FAULT);
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        jump;
    logic [25:0] jump_target;
    logic        branch;
    logic [15:0] branch_offset;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        fetch_fault;

    logic        d2_req;
    logic [31:0] d2_addr;
    logic [31:0] d2_instr;
    logic [31:0] d2_instr_pc;
    logic        d2_valid;
    logic        d2_fault;

    int tests = 0;
    int fails = 0;

    fetch_sequencer #(
        .RESET_PC  (32'h0000_0000),
        .WAIT_LIMIT(3)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_ack_i     (imem_ack),
        .imem_rdata_i   (imem_rdata),
        .instr_o        (instr),
        .instr_pc_o     (instr_pc),
        .instr_valid_o  (instr_valid),
        .stall_i        (stall),
        .jump_i         (jump),
        .jump_target_i  (jump_target),
        .branch_i       (branch),
        .branch_offset_i(branch_offset),
        .fetch_fault_o  (fetch_fault)
    );

    // Second instance starting at a high address, used for the jump cases
    // that need non-zero upper PC bits.
    fetch_sequencer #(
        .RESET_PC  (32'h4000_0010),
        .WAIT_LIMIT(3)
    ) dut2 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .imem_req_o     (d2_req),
        .imem_addr_o    (d2_addr),
        .imem_ack_i     (imem_ack),
        .imem_rdata_i   (imem_rdata),
        .instr_o        (d2_instr),
        .instr_pc_o     (d2_instr_pc),
        .instr_valid_o  (d2_valid),
        .stall_i        (stall),
        .jump_i         (jump),
        .jump_target_i  (jump_target),
        .branch_i       (branch),
        .branch_offset_i(branch_offset),
        .fetch_fault_o  (d2_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] word;
        logic        jmp;
        logic [25:0] tgt;
        logic        br;
        logic [15:0] off;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Next-PC rule from the instruction's own address, in plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic j,
                                               input logic [25:0] t, input logic b,
                                               input logic [15:0] o);
        logic [31:0] p4;
        int signed   off_s;
        p4 = pc + 32'd4;
        off_s = int'($signed(o));
        if (j) return (p4 & 32'hF000_0000) + (32'(t) * 32'd4);
        if (b) return p4 + 32'(off_s * 4);
        return p4;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
        jump = 1'b0; jump_target = 26'd0; branch = 1'b0; branch_offset = 16'd0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("wait_req", 32'(imem_req), 32'd1);
    endtask

    task automatic xact(input logic [31:0] word, input int ack_dly, input int stall_n,
                        input logic en_after, input logic j, input logic [25:0] t,
                        input logic b, input logic [15:0] o,
                        input logic [31:0] exp_pc, input logic [31:0] exp_next);
        wait_req();
        chk("addr", imem_addr, exp_pc);
        for (int k = 0; k < ack_dly; k++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            chk("req_hold", 32'(imem_req), 32'd1);
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        chk("valid", 32'(instr_valid), 32'd1);
        chk("instr", instr, word);
        chk("instr_pc", instr_pc, exp_pc);
        chk("req_in_valid", 32'(imem_req), 32'd0);
        stall = 1'b1;
        for (int k = 0; k < stall_n; k++) begin
            jump = 1'($urandom_range(0, 1));
            branch = 1'($urandom_range(0, 1));
            jump_target = 26'($urandom);
            imem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", instr, word);
            chk("stall_instr_pc", instr_pc, exp_pc);
            chk("stall_req", 32'(imem_req), 32'd0);
        end
        imem_ack = 1'b0;
        stall = 1'b0;
        jump = j; jump_target = t; branch = b; branch_offset = o;
        enable = en_after;
        @(negedge clk);
        jump = 1'b0;
        branch = 1'b0;
        chk("valid_drop", 32'(instr_valid), 32'd0);
        if (!en_after) begin
            chk("idle_req", 32'(imem_req), 32'd0);
            chk("idle_addr_hold", imem_addr, exp_pc);
            enable = 1'b1;
            @(negedge clk);
        end
        chk("next_req", 32'(imem_req), 32'd1);
        chk("next_addr", imem_addr, exp_next);
    endtask

    initial begin
        logic [31:0] pc_m;
        logic [31:0] w;
        logic        rj, rb, re;
        logic [25:0] rt;
        logic [15:0] ro;
        int          cnt;

        vt[0] = '{32'h1111_1111, 1'b0, 26'h0, 1'b0, 16'h0000, 32'h0000_0000, 32'h0000_0004};
        vt[1] = '{32'h2222_2222, 1'b0, 26'h0, 1'b0, 16'h0000, 32'h0000_0004, 32'h0000_0008};
        vt[2] = '{32'h3333_3333, 1'b1, 26'h8, 1'b0, 16'h0000, 32'h0000_0008, 32'h0000_0020};
        vt[3] = '{32'h4444_4444, 1'b0, 26'h0, 1'b1, 16'hFFFE, 32'h0000_0020, 32'h0000_001C};
        vt[4] = '{32'h5555_5555, 1'b0, 26'h0, 1'b1, 16'hFFF7, 32'h0000_001C, 32'hFFFF_FFFC};
        vt[5] = '{32'h6666_6666, 1'b0, 26'h0, 1'b0, 16'h0000, 32'hFFFF_FFFC, 32'h0000_0000};
        vt[6] = '{32'h7777_7777, 1'b1, 26'h3, 1'b1, 16'h0100, 32'h0000_0000, 32'h0000_000C};
        vt[7] = '{32'h8888_8888, 1'b0, 26'h0, 1'b1, 16'h0004, 32'h0000_000C, 32'h0000_0020};

        // Table-driven sequential / redirect / wrap cases
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            xact(vt[i].word, 0, 0, 1'b1, vt[i].jmp, vt[i].tgt, vt[i].br, vt[i].off,
                 vt[i].exp_pc, vt[i].exp_next);
            $display("[TB] vec %0d pc=0x%08h next=0x%08h", i, vt[i].exp_pc, vt[i].exp_next);
        end

        // Stall 5 cycles with jump toggling, then release with no redirect
        xact(32'hCAFE_0001, 0, 5, 1'b1, 1'b0, 26'h0, 1'b0, 16'h0, 32'h0000_0020, 32'h0000_0024);
        $display("[TB] stall pc=0x00000020 next=0x00000024");

        // Randomized transactions against the arithmetic model
        pc_m = 32'h0000_0024;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] nxt;
            int ad, sn;
            w  = $urandom;
            rj = ($urandom_range(0, 3) == 0);
            rb = ($urandom_range(0, 2) == 0);
            rt = 26'($urandom);
            ro = 16'($urandom);
            re = ($urandom_range(0, 3) != 0);
            ad = $urandom_range(0, 3);
            sn = $urandom_range(0, 3);
            nxt = model_next(pc_m, rj, rt, rb, ro);
            xact(w, ad, sn, re, rj, rt, rb, ro, pc_m, nxt);
            $display("[TB] rand %0d pc=0x%08h j=%0d b=%0d next=0x%08h", i, pc_m, rj, rb, nxt);
            pc_m = nxt;
        end

        // Jump from a high PC; then jump and branch together (jump wins)
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        chk("d2_req", 32'(d2_req), 32'd1);
        chk("d2_addr", d2_addr, 32'h4000_0010);
        imem_ack = 1'b1; imem_rdata = 32'h0800_0100;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("d2_instr_pc", d2_instr_pc, 32'h4000_0010);
        jump = 1'b1; jump_target = 26'h0000100;
        @(negedge clk);
        jump = 1'b0;
        chk("d2_jump_addr", d2_addr, 32'h4000_0400);
        $display("[TB] jump pc=0x40000010 next=0x%08h", d2_addr);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        jump = 1'b1; jump_target = 26'h0000200; branch = 1'b1; branch_offset = 16'h0010;
        @(negedge clk);
        jump = 1'b0; branch = 1'b0;
        chk("d2_jump_wins", d2_addr, 32'h4000_0800);
        $display("[TB] jump+branch pc=0x40000400 next=0x%08h", d2_addr);

        // Timeout: never ack -> four request cycles then sticky fault
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        cnt = 0;
        while (imem_req && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", 32'(cnt), 32'd4);
        chk("fault_set", 32'(fetch_fault), 32'd1);
        for (int k = 0; k < 4; k++) begin
            enable = 1'($urandom_range(0, 1));
            imem_ack = 1'b1;
            @(negedge clk);
            chk("fault_sticky", 32'(fetch_fault), 32'd1);
            chk("fault_no_req", 32'(imem_req), 32'd0);
            chk("fault_no_valid", 32'(instr_valid), 32'd0);
        end
        imem_ack = 1'b0;
        $display("[TB] timeout req_cycles=%0d fault=%0d", cnt, fetch_fault);

        // Async reset while faulted clears the flag immediately
        #2 rst_n = 1'b0;
        #1 chk("async_fault_clr", 32'(fetch_fault), 32'd0);
        @(negedge clk);

        // Ack on the last tolerated cycle -> normal VALID, no fault
        do_reset();
        enable = 1'b1;
        xact(32'hABCD_1234, 3, 0, 1'b1, 1'b0, 26'h0, 1'b0, 16'h0, 32'h0000_0000, 32'h0000_0004);
        chk("late_ack_no_fault", 32'(fetch_fault), 32'd0);
        $display("[TB] late ack pc=0x00000000 fault=%0d", fetch_fault);

        // Async reset between edges while requesting
        chk("pre_async_req", 32'(imem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_valid", 32'(instr_valid), 32'd0);
        chk("async_fault", 32'(fetch_fault), 32'd0);
        chk("async_addr", imem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_req();
        chk("post_reset_addr", imem_addr, 32'h0000_0000);
        $display("[TB] async reset mid-REQ addr=0x%08h", imem_addr);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
